mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 128, cache-line data width; STRB_W, DATA_W/8 = 16, write strobe width; MSG_W, 32, write-response message width.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 Instruction-cache bundle, prefix Inst_Cahe_. Inputs: readAddr_addr[ADDR_W], readAddr_valid, readData_ready, writeAddr_addr[ADDR_W], writeAddr_valid, writeData_data[DATA_W], writeData_strb[STRB_W], writeData_valid, writeResp_ready.
REQ-005 Instruction-cache bundle outputs: readAddr_ready, readData_data[DATA_W], readData_valid, writeAddr_ready, writeData_ready, writeResp_msg[MSG_W], writeResp_valid.
REQ-006 Data-cache bundle, prefix Data_Cahe_, SHALL use signals identical in name suffix, width and direction to REQ-004/005.
REQ-007 Memory bundle, prefix Mem_, SHALL mirror REQ-004/005 with directions reversed: arbiter drives addr/valid/data/strb/ready, memory drives ready/data/valid/msg.
REQ-008 grant  out  2  current owner: 2'b00 none, 2'b01 Inst, 2'b10 Data.
REQ-009 busy  out  1  high in every state except IDLE.

Function
REQ-010 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; exactly one transaction (one read or one write) owns the Mem port at a time.
REQ-011 A master requests when its readAddr_valid or writeAddr_valid is high; requests are sampled only in IDLE.
REQ-012 Arbitration is round-robin: a single requester wins; if both request, the master not equal to last_grant wins.
REQ-013 Within the winning master, a pending write (writeAddr_valid) takes precedence over a pending read.
REQ-014 IDLE -> WR_REQ or RD_ADDR on the next edge, with owner and last_grant registered; arbitration latency is 1 cycle, and no Mem valid is asserted in IDLE.
REQ-015 RD_ADDR: Mem_readAddr_* = owner readAddr_*; owner readAddr_ready = Mem_readAddr_ready; on valid&ready -> RD_DATA.
REQ-016 RD_DATA: owner readData_data/valid = Mem_readData_*; Mem_readData_ready = owner readData_ready; on valid&ready (single 128-bit beat) -> IDLE.
REQ-017 WR_REQ forwards writeAddr and writeData concurrently; sticky flags aw_done and w_done set on the respective handshakes; after a channel's handshake its Mem valid is forced low; when both flags are set (including same cycle) -> WR_RESP.
REQ-018 WR_RESP: owner writeResp_msg/valid = Mem_writeResp_*; Mem_writeResp_ready = owner writeResp_ready; on valid&ready -> IDLE, flags cleared.
REQ-019 The non-owner master SHALL see all its ready and valid outputs at 0; data/msg outputs to the non-owner are 0.
REQ-020 Mem channels not active in the current state: valid 0, ready 0, addr/data/strb 0; memory responses arriving unexpectedly (e.g. Mem_readData_valid in IDLE) are not acknowledged and are ignored.
REQ-021 The forwarding path is combinational once the state is registered; no added latency per channel beyond the handshake.
REQ-022 Masters hold valid until ready; a request that appears while the other master owns the port waits in IDLE arbitration without loss.
REQ-023 Back-to-back: the cycle after return to IDLE, a new arbitration occurs; worst-case wait for a master is one full transaction of the other.

Reset
REQ-024 rst low asynchronously forces: state IDLE, grant 00, busy 0, aw_done=w_done=0, last_grant=Data (Inst wins the first tie), and all valid/ready outputs 0.
REQ-025 Reset asserted mid-transaction aborts it with no completion signalled to either master; operation resumes from IDLE after rst rises.

Verification
REQ-026 Inst read only, addr 0x0000_1000, Mem ready immediately, readData 0xA5..A5 one cycle later -> Inst sees ready, then data 0xA5..A5 valid; grant 01 for 3 cycles; Data outputs all 0.
REQ-027 Both masters request a read in the same cycle after reset -> Inst served first, Data granted the cycle after Inst's readData handshake; the next tie goes to Inst.
REQ-028 Data write, addr 0x8000_0040, strb 0xFFFF, Mem_writeData_ready 2 cycles after Mem_writeAddr_ready -> aw_done then w_done, WR_RESP, msg 0x0000_0000 returned to Data; Mem valids drop after their own handshakes.
REQ-029 Data raises read and write together -> write completes through WR_RESP before the read is forwarded.
REQ-030 rst pulled low during RD_DATA with Mem_readData_valid high -> outputs 0 immediately without a clock edge; after release, a re-issued request completes normally.
REQ-031 Mem_readData_valid=1 while IDLE -> Mem_readData_ready stays 0 and both masters' readData_valid stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one memory port between
// instruction and data caches; one read or write transaction at a time.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int STRB_W = DATA_W / 8,
  parameter int MSG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Inst_Cahe_readAddr_addr,
  input  logic              Inst_Cahe_readAddr_valid,
  output logic              Inst_Cahe_readAddr_ready,
  output logic [DATA_W-1:0] Inst_Cahe_readData_data,
  output logic              Inst_Cahe_readData_valid,
  input  logic              Inst_Cahe_readData_ready,
  input  logic [ADDR_W-1:0] Inst_Cahe_writeAddr_addr,
  input  logic              Inst_Cahe_writeAddr_valid,
  output logic              Inst_Cahe_writeAddr_ready,
  input  logic [DATA_W-1:0] Inst_Cahe_writeData_data,
  input  logic [STRB_W-1:0] Inst_Cahe_writeData_strb,
  input  logic              Inst_Cahe_writeData_valid,
  output logic              Inst_Cahe_writeData_ready,
  output logic [MSG_W-1:0]  Inst_Cahe_writeResp_msg,
  output logic              Inst_Cahe_writeResp_valid,
  input  logic              Inst_Cahe_writeResp_ready,
  input  logic [ADDR_W-1:0] Data_Cahe_readAddr_addr,
  input  logic              Data_Cahe_readAddr_valid,
  output logic              Data_Cahe_readAddr_ready,
  output logic [DATA_W-1:0] Data_Cahe_readData_data,
  output logic              Data_Cahe_readData_valid,
  input  logic              Data_Cahe_readData_ready,
  input  logic [ADDR_W-1:0] Data_Cahe_writeAddr_addr,
  input  logic              Data_Cahe_writeAddr_valid,
  output logic              Data_Cahe_writeAddr_ready,
  input  logic [DATA_W-1:0] Data_Cahe_writeData_data,
  input  logic [STRB_W-1:0] Data_Cahe_writeData_strb,
  input  logic              Data_Cahe_writeData_valid,
  output logic              Data_Cahe_writeData_ready,
  output logic [MSG_W-1:0]  Data_Cahe_writeResp_msg,
  output logic              Data_Cahe_writeResp_valid,
  input  logic              Data_Cahe_writeResp_ready,
  output logic [ADDR_W-1:0] Mem_readAddr_addr,
  output logic              Mem_readAddr_valid,
  input  logic              Mem_readAddr_ready,
  input  logic [DATA_W-1:0] Mem_readData_data,
  input  logic              Mem_readData_valid,
  output logic              Mem_readData_ready,
  output logic [ADDR_W-1:0] Mem_writeAddr_addr,
  output logic              Mem_writeAddr_valid,
  input  logic              Mem_writeAddr_ready,
  output logic [DATA_W-1:0] Mem_writeData_data,
  output logic [STRB_W-1:0] Mem_writeData_strb,
  output logic              Mem_writeData_valid,
  input  logic              Mem_writeData_ready,
  input  logic [MSG_W-1:0]  Mem_writeResp_msg,
  input  logic              Mem_writeResp_valid,
  output logic              Mem_writeResp_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP
  } state_t;

  state_t state, stateNxt;
  logic owner, ownerNxt;
  logic lastGrant, lastGrantNxt;
  logic awDone, awDoneNxt;
  logic wDone, wDoneNxt;

  logic instReq, dataReq, win, winWrite;
  logic awFire, wFire;

  // owner-selected master request side
  logic [ADDR_W-1:0] raAddr, waAddr;
  logic [DATA_W-1:0] wdData;
  logic [STRB_W-1:0] wdStrb;
  logic raValid, rdReady, waValid, wdValid, wrReady;

  // owner-side responses, steered to one master below
  logic [DATA_W-1:0] rdData;
  logic [MSG_W-1:0]  wrMsg;
  logic raReady, rdValid, waReady, wdReady, wrValid;

  assign raAddr  = owner ? Data_Cahe_readAddr_addr   : Inst_Cahe_readAddr_addr;
  assign raValid = owner ? Data_Cahe_readAddr_valid  : Inst_Cahe_readAddr_valid;
  assign rdReady = owner ? Data_Cahe_readData_ready  : Inst_Cahe_readData_ready;
  assign waAddr  = owner ? Data_Cahe_writeAddr_addr  : Inst_Cahe_writeAddr_addr;
  assign waValid = owner ? Data_Cahe_writeAddr_valid : Inst_Cahe_writeAddr_valid;
  assign wdData  = owner ? Data_Cahe_writeData_data  : Inst_Cahe_writeData_data;
  assign wdStrb  = owner ? Data_Cahe_writeData_strb  : Inst_Cahe_writeData_strb;
  assign wdValid = owner ? Data_Cahe_writeData_valid : Inst_Cahe_writeData_valid;
  assign wrReady = owner ? Data_Cahe_writeResp_ready : Inst_Cahe_writeResp_ready;

  assign instReq = Inst_Cahe_readAddr_valid | Inst_Cahe_writeAddr_valid;
  assign dataReq = Data_Cahe_readAddr_valid | Data_Cahe_writeAddr_valid;
  // win: 1 = Data; on a tie the master that did not win last time goes
  assign win      = (instReq & dataReq) ? ~lastGrant : ~instReq;
  assign winWrite = win ? Data_Cahe_writeAddr_valid : Inst_Cahe_writeAddr_valid;

  assign awFire = waValid & ~awDone & Mem_writeAddr_ready;
  assign wFire  = wdValid & ~wDone & Mem_writeData_ready;

  assign busy  = (state != IDLE);
  assign grant = !busy ? 2'b00 : (owner ? 2'b10 : 2'b01);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      awDone    <= 1'b0;
      wDone     <= 1'b0;
    end else begin
      state     <= stateNxt;
      owner     <= ownerNxt;
      lastGrant <= lastGrantNxt;
      awDone    <= awDoneNxt;
      wDone     <= wDoneNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    ownerNxt     = owner;
    lastGrantNxt = lastGrant;
    awDoneNxt    = awDone;
    wDoneNxt     = wDone;
    Mem_readAddr_addr   = '0;
    Mem_readAddr_valid  = 1'b0;
    Mem_readData_ready  = 1'b0;
    Mem_writeAddr_addr  = '0;
    Mem_writeAddr_valid = 1'b0;
    Mem_writeData_data  = '0;
    Mem_writeData_strb  = '0;
    Mem_writeData_valid = 1'b0;
    Mem_writeResp_ready = 1'b0;
    raReady = 1'b0;
    rdData  = '0;
    rdValid = 1'b0;
    waReady = 1'b0;
    wdReady = 1'b0;
    wrMsg   = '0;
    wrValid = 1'b0;
    case (state)
      IDLE: begin
        if (instReq | dataReq) begin
          ownerNxt     = win;
          lastGrantNxt = win;
          stateNxt     = winWrite ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        Mem_readAddr_addr  = raAddr;
        Mem_readAddr_valid = raValid;
        raReady            = Mem_readAddr_ready;
        if (raValid & Mem_readAddr_ready) stateNxt = RD_DATA;
      end
      RD_DATA: begin
        rdData             = Mem_readData_data;
        rdValid            = Mem_readData_valid;
        Mem_readData_ready = rdReady;
        if (Mem_readData_valid & rdReady) stateNxt = IDLE;
      end
      WR_REQ: begin
        Mem_writeAddr_addr  = waAddr;
        Mem_writeAddr_valid = waValid & ~awDone;
        waReady             = Mem_writeAddr_ready & ~awDone;
        Mem_writeData_data  = wdData;
        Mem_writeData_strb  = wdStrb;
        Mem_writeData_valid = wdValid & ~wDone;
        wdReady             = Mem_writeData_ready & ~wDone;
        awDoneNxt           = awDone | awFire;
        wDoneNxt            = wDone | wFire;
        if ((awDone | awFire) & (wDone | wFire)) stateNxt = WR_RESP;
      end
      WR_RESP: begin
        wrMsg               = Mem_writeResp_msg;
        wrValid             = Mem_writeResp_valid;
        Mem_writeResp_ready = wrReady;
        if (Mem_writeResp_valid & wrReady) begin
          stateNxt  = IDLE;
          awDoneNxt = 1'b0;
          wDoneNxt  = 1'b0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    Inst_Cahe_readAddr_ready  = 1'b0;
    Inst_Cahe_readData_data   = '0;
    Inst_Cahe_readData_valid  = 1'b0;
    Inst_Cahe_writeAddr_ready = 1'b0;
    Inst_Cahe_writeData_ready = 1'b0;
    Inst_Cahe_writeResp_msg   = '0;
    Inst_Cahe_writeResp_valid = 1'b0;
    Data_Cahe_readAddr_ready  = 1'b0;
    Data_Cahe_readData_data   = '0;
    Data_Cahe_readData_valid  = 1'b0;
    Data_Cahe_writeAddr_ready = 1'b0;
    Data_Cahe_writeData_ready = 1'b0;
    Data_Cahe_writeResp_msg   = '0;
    Data_Cahe_writeResp_valid = 1'b0;
    if (owner) begin
      Data_Cahe_readAddr_ready  = raReady;
      Data_Cahe_readData_data   = rdData;
      Data_Cahe_readData_valid  = rdValid;
      Data_Cahe_writeAddr_ready = waReady;
      Data_Cahe_writeData_ready = wdReady;
      Data_Cahe_writeResp_msg   = wrMsg;
      Data_Cahe_writeResp_valid = wrValid;
    end else begin
      Inst_Cahe_readAddr_ready  = raReady;
      Inst_Cahe_readData_data   = rdData;
      Inst_Cahe_readData_valid  = rdValid;
      Inst_Cahe_writeAddr_ready = waReady;
      Inst_Cahe_writeData_ready = wdReady;
      Inst_Cahe_writeResp_msg   = wrMsg;
      Inst_Cahe_writeResp_valid = wrValid;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table for read
// arbitration plus hand sequences for writes and mid-transaction reset.
module tb_mem_arbiter;

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] WPAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] iRaAddr, iWaAddr, dRaAddr, dWaAddr, mRaAddr, mWaAddr;
  logic [127:0] iRdData, iWdData, dRdData, dWdData, mRdData, mWdData;
  logic [15:0] iWdStrb, dWdStrb, mWdStrb;
  logic [31:0] iWrMsg, dWrMsg, mWrMsg;
  logic iRaV, iRaR, iRdV, iRdR, iWaV, iWaR, iWdV, iWdR, iWrV, iWrR;
  logic dRaV, dRaR, dRdV, dRdR, dWaV, dWaR, dWdV, dWdR, dWrV, dWrR;
  logic mRaV, mRaR, mRdV, mRdR, mWaV, mWaR, mWdV, mWdR, mWrV, mWrR;
  logic [1:0] grant;
  logic busy;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .Inst_Cahe_readAddr_addr(iRaAddr), .Inst_Cahe_readAddr_valid(iRaV),
    .Inst_Cahe_readAddr_ready(iRaR), .Inst_Cahe_readData_data(iRdData),
    .Inst_Cahe_readData_valid(iRdV), .Inst_Cahe_readData_ready(iRdR),
    .Inst_Cahe_writeAddr_addr(iWaAddr), .Inst_Cahe_writeAddr_valid(iWaV),
    .Inst_Cahe_writeAddr_ready(iWaR), .Inst_Cahe_writeData_data(iWdData),
    .Inst_Cahe_writeData_strb(iWdStrb), .Inst_Cahe_writeData_valid(iWdV),
    .Inst_Cahe_writeData_ready(iWdR), .Inst_Cahe_writeResp_msg(iWrMsg),
    .Inst_Cahe_writeResp_valid(iWrV), .Inst_Cahe_writeResp_ready(iWrR),
    .Data_Cahe_readAddr_addr(dRaAddr), .Data_Cahe_readAddr_valid(dRaV),
    .Data_Cahe_readAddr_ready(dRaR), .Data_Cahe_readData_data(dRdData),
    .Data_Cahe_readData_valid(dRdV), .Data_Cahe_readData_ready(dRdR),
    .Data_Cahe_writeAddr_addr(dWaAddr), .Data_Cahe_writeAddr_valid(dWaV),
    .Data_Cahe_writeAddr_ready(dWaR), .Data_Cahe_writeData_data(dWdData),
    .Data_Cahe_writeData_strb(dWdStrb), .Data_Cahe_writeData_valid(dWdV),
    .Data_Cahe_writeData_ready(dWdR), .Data_Cahe_writeResp_msg(dWrMsg),
    .Data_Cahe_writeResp_valid(dWrV), .Data_Cahe_writeResp_ready(dWrR),
    .Mem_readAddr_addr(mRaAddr), .Mem_readAddr_valid(mRaV),
    .Mem_readAddr_ready(mRaR), .Mem_readData_data(mRdData),
    .Mem_readData_valid(mRdV), .Mem_readData_ready(mRdR),
    .Mem_writeAddr_addr(mWaAddr), .Mem_writeAddr_valid(mWaV),
    .Mem_writeAddr_ready(mWaR), .Mem_writeData_data(mWdData),
    .Mem_writeData_strb(mWdStrb), .Mem_writeData_valid(mWdV),
    .Mem_writeData_ready(mWdR), .Mem_writeResp_msg(mWrMsg),
    .Mem_writeResp_valid(mWrV), .Mem_writeResp_ready(mWrR),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic rst, iRaV, iRdR, dRaV, dRdR, mRaR, mRdV;
    logic [1:0] g;
    logic b, iRaR, iRdV, dRaR, dRdV, mRaV, mRdR;
    logic [31:0] a;
  } vec_t;

  int nChk = 0;
  int nFail = 0;
  vec_t vec [18];

  function automatic vec_t mk(input logic [6:0] in, input logic [1:0] g,
                              input logic [6:0] e, input logic [31:0] a);
    return vec_t'({in, g, e, a});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clrIn();
    iRaV = 0; iRdR = 0; iWaV = 0; iWdV = 0; iWrR = 0;
    dRaV = 0; dRdR = 0; dWaV = 0; dWdV = 0; dWrR = 0;
    mRaR = 0; mRdV = 0; mWaR = 0; mWdR = 0; mWrV = 0;
    mRdData = '0; mWrMsg = '0;
    iWdData = '0; iWdStrb = '0; dWdData = '0; dWdStrb = '0;
    iRaAddr = 32'h0000_1000; dRaAddr = 32'h0000_2000;
    iWaAddr = 32'h0000_5000; dWaAddr = 32'h0000_3000;
  endtask

  initial begin
    rst = 0;
    clrIn();
    vec[0]  = mk(7'b1100000, 2'b00, 7'b0000000, 32'h0);
    vec[1]  = mk(7'b1110010, 2'b01, 7'b1100010, 32'h1000);
    vec[2]  = mk(7'b1010000, 2'b01, 7'b1000001, 32'h0);
    vec[3]  = mk(7'b1010001, 2'b01, 7'b1010001, 32'h0);
    vec[4]  = mk(7'b1000000, 2'b00, 7'b0000000, 32'h0);
    vec[5]  = mk(7'b0000000, 2'b00, 7'b0000000, 32'h0);
    vec[6]  = mk(7'b1101000, 2'b00, 7'b0000000, 32'h0);
    vec[7]  = mk(7'b1111110, 2'b01, 7'b1100010, 32'h1000);
    vec[8]  = mk(7'b1011101, 2'b01, 7'b1010001, 32'h0);
    vec[9]  = mk(7'b1001000, 2'b00, 7'b0000000, 32'h0);
    vec[10] = mk(7'b1001110, 2'b10, 7'b1001010, 32'h2000);
    vec[11] = mk(7'b1000101, 2'b10, 7'b1000101, 32'h0);
    vec[12] = mk(7'b1101000, 2'b00, 7'b0000000, 32'h0);
    vec[13] = mk(7'b1101000, 2'b01, 7'b1000010, 32'h1000);
    vec[14] = mk(7'b1101010, 2'b01, 7'b1100010, 32'h1000);
    vec[15] = mk(7'b1001001, 2'b01, 7'b1010000, 32'h0);
    vec[16] = mk(7'b1011001, 2'b01, 7'b1010001, 32'h0);
    vec[17] = mk(7'b1000001, 2'b00, 7'b0000000, 32'h0);

    @(negedge clk);
    #1;
    chk("reset ctrl", {grant, busy, iRaR, iRdV, dRaR, dRdV, mRaV, mRdR}, '0);
    chk("reset wr", {iWaR, iWdR, iWrV, dWaR, dWdR, dWrV, mWaV, mWdV, mWrR}, '0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vec[i].rst;
      iRaV = vec[i].iRaV; iRdR = vec[i].iRdR;
      dRaV = vec[i].dRaV; dRdR = vec[i].dRdR;
      mRaR = vec[i].mRaR; mRdV = vec[i].mRdV;
      mRdData = vec[i].mRdV ? A5 : '0;
      #1;
      chk($sformatf("vec%0d ctrl", i),
          {grant, busy, iRaR, iRdV, dRaR, dRdV, mRaV, mRdR},
          {vec[i].g, vec[i].b, vec[i].iRaR, vec[i].iRdV, vec[i].dRaR,
           vec[i].dRdV, vec[i].mRaV, vec[i].mRdR});
      chk($sformatf("vec%0d addr", i), mRaAddr, vec[i].a);
      chk($sformatf("vec%0d iData", i), iRdData, vec[i].iRdV ? A5 : '0);
      chk($sformatf("vec%0d dData", i), dRdData, vec[i].dRdV ? A5 : '0);
      chk($sformatf("vec%0d wrIdle", i),
          {iWaR, iWdR, iWrV, dWaR, dWdR, dWrV, mWaV, mWdV, mWrR}, '0);
    end

    // Data write: address accepted first, data two cycles later
    @(negedge clk);
    clrIn();
    dWaAddr = 32'h8000_0040; dWaV = 1; dWdV = 1;
    dWdData = WPAT; dWdStrb = 16'hFFFF;
    #1;
    chk("w idle", {grant, busy, mWaV, mWdV}, '0);
    @(negedge clk);
    mWaR = 1;
    #1;
    chk("w aw ctrl", {grant, mWaV, dWaR, mWdV, dWdR}, {2'b10, 4'b1110});
    chk("w aw addr", mWaAddr, 32'h8000_0040);
    chk("w wd data", mWdData, WPAT);
    chk("w wd strb", mWdStrb, 16'hFFFF);
    chk("w iSide", {iRaR, iRdV, iWaR, iWdR, iWrV}, '0);
    @(negedge clk);
    dWaV = 0; mWaR = 0;
    #1;
    chk("w awDrop", {busy, mWaV, mWdV, dWdR}, 4'b1010);
    @(negedge clk);
    mWdR = 1;
    #1;
    chk("w wd hs", {grant, mWaV, mWdV, dWdR}, {2'b10, 3'b011});
    @(negedge clk);
    dWdV = 0; mWdR = 0; mWrV = 1; mWrMsg = 32'h0; dWrR = 1;
    #1;
    chk("w resp", {grant, busy, mWaV, mWdV, dWrV, mWrR, iWrV},
        {2'b10, 5'b10011, 1'b0});
    chk("w msg", dWrMsg, 32'h0);
    @(negedge clk);
    clrIn();
    #1;
    chk("w done", {grant, busy}, '0);

    // Data read and write together: write goes first
    @(negedge clk);
    dRaV = 1; dWaV = 1; dWdV = 1; dWdData = WPAT; dWdStrb = 16'h00FF;
    #1;
    chk("rw idle", {grant, busy}, '0);
    @(negedge clk);
    mWaR = 1; mWdR = 1;
    #1;
    chk("rw wreq", {grant, mWaV, mWdV, mRaV, dRaR}, {2'b10, 4'b1100});
    @(negedge clk);
    dWaV = 0; dWdV = 0; mWaR = 0; mWdR = 0;
    mWrV = 1; mWrMsg = 32'h1234_5678; dWrR = 1;
    #1;
    chk("rw resp", {grant, dWrV, mWrR, mRaV}, {2'b10, 3'b110});
    chk("rw msg", dWrMsg, 32'h1234_5678);
    @(negedge clk);
    mWrV = 0; mWrMsg = '0; dWrR = 0;
    #1;
    chk("rw idle2", {grant, busy, mRaV}, '0);
    @(negedge clk);
    mRaR = 1;
    #1;
    chk("rw rd", {grant, mRaV, dRaR}, {2'b10, 2'b11});
    chk("rw rd addr", mRaAddr, 32'h0000_2000);
    @(negedge clk);
    dRaV = 0; mRaR = 0; mRdV = 1; mRdData = A5; dRdR = 1;
    #1;
    chk("rw rdData", {dRdV, mRdR, iRdV}, 3'b110);
    chk("rw rdData val", dRdData, A5);
    @(negedge clk);
    clrIn();

    // Reset during RD_DATA drops outputs without a clock edge
    iRaV = 1;
    @(negedge clk);
    mRaR = 1;
    @(negedge clk);
    iRaV = 0; mRaR = 0; mRdV = 1; mRdData = A5;
    #1;
    chk("rr pre", {grant, iRdV, mRdR}, {2'b01, 2'b10});
    #2;
    rst = 0;
    #1;
    chk("rr async", {grant, busy, iRdV, mRdR, iRaR, mRaV}, '0);
    chk("rr data", iRdData, '0);
    @(negedge clk);
    rst = 1; mRdV = 0; mRdData = '0; iRaV = 1;
    @(negedge clk);
    mRaR = 1; iRdR = 1;
    #1;
    chk("rr reissue", {grant, iRaR, mRaV}, {2'b01, 2'b11});
    @(negedge clk);
    iRaV = 0; mRaR = 0; mRdV = 1; mRdData = A5;
    #1;
    chk("rr rdData", {grant, iRdV, mRdR}, {2'b01, 2'b11});
    @(negedge clk);
    clrIn();
    #1;
    chk("rr done", {grant, busy}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
